// File: rtl/axil_interface_if.sv
// AXI-lite interface bundle shared by the arbiter's requester and memory ports.
//   rd_mst / rd_slv : AR + R channels (master drives address and rready)
//   wr_mst / wr_slv : AW + W + B channels (master drives address, data and bready)
// Each bus instance only uses the channels of the modport it is bound to.
interface axil_interface_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport rd_mst (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport rd_slv (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
  modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  input  awready, wready, bresp, bvalid);
  modport wr_slv (input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  output awready, wready, bresp, bvalid);
endinterface

// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter: shares one AXI-lite memory port between instruction fetch
// (read-only) and the memory stage (loads/stores), one transaction at a time.
// Requests pass through combinationally; responses route to the owner.
//
// Ports:
//   clk            clock, posedge
//   rst            asynchronous active-low reset
//   if_rd          fetch read requester (rd_slv)
//   ls_rd / ls_wr  memory-stage read / write requesters (rd_slv / wr_slv)
//   mem_rd/mem_wr  shared memory read / write port (rd_mst / wr_mst)
//   if_kill        fetch redirect; an outstanding fetch response is discarded
//   busy           high whenever the FSM is not IDLE
// Optional (macro AXIL_ARB_PERF_CNT_EN): if_grant_cnt, ls_grant_cnt, starve_cnt.
//
// state      | meaning
// IDLE       | no transaction; grant decided combinationally
// RD_WAIT_IF | fetch read address accepted, waiting for R
// RD_WAIT_LS | memory-stage read address accepted, waiting for R
// WR_ADDR    | one of AW/W accepted, the other still driven
// WR_RESP    | AW and W both accepted, waiting for B
module axil_mem_arbiter #(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  axil_interface_if.rd_slv    if_rd,
  axil_interface_if.rd_slv    ls_rd,
  axil_interface_if.wr_slv    ls_wr,
  axil_interface_if.rd_mst    mem_rd,
  axil_interface_if.wr_mst    mem_wr,
  input  logic                if_kill,
  output logic                busy
`ifdef AXIL_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         if_grant_cnt,
  output logic [31:0]         ls_grant_cnt,
  output logic [31:0]         starve_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT_IF = 3'd1,
    RD_WAIT_LS = 3'd2,
    WR_ADDR    = 3'd3,
    WR_RESP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IF   = 2'd1,
    G_LSR  = 2'd2,
    G_LSW  = 2'd3
  } gnt_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  state_t     state_q, state_d;
  gnt_t       gnt;
  gnt_t       lock_q, lock_d;
  logic [3:0] streak_q, streak_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       drop_q, drop_d;
  logic       en_q;

  logic ls_wr_req, ls_req, lock_held;
  logic rd_sel_if, rd_sel_ls, wr_sel_idle, wr_addr_st;
  logic mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready;
  logic drop_now;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic if_grant_ev, ls_grant_ev;

  // en_q holds all grants and valids at zero while reset is asserted and
  // for the first edge after release, so nothing leaks through the
  // combinational paths while the block is held in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lock_q    <= G_NONE;
      streak_q  <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      drop_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      streak_q  <= streak_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      drop_q    <= drop_d;
      en_q      <= 1'b1;
    end
  end

  // Grant selection. A granted request that has not handshaken yet is
  // locked so the grant cannot move while its valid is held.
  always_comb begin
    ls_wr_req = ls_wr.awvalid | ls_wr.wvalid;
    ls_req    = ls_rd.arvalid | ls_wr_req;
    case (lock_q)
      G_IF:    lock_held = if_rd.arvalid;
      G_LSR:   lock_held = ls_rd.arvalid;
      G_LSW:   lock_held = ls_wr_req;
      default: lock_held = 1'b0;
    endcase
    gnt = G_NONE;
    if (!en_q || state_q != IDLE)                                gnt = G_NONE;
    else if (lock_held)                                          gnt = lock_q;
    else if (if_rd.arvalid && (!ls_req || streak_q == STREAK_MAX)) gnt = G_IF;
    else if (ls_rd.arvalid)                                      gnt = G_LSR;
    else if (ls_wr_req)                                          gnt = G_LSW;
  end

  // Read channels
  always_comb begin
    rd_sel_if      = (gnt == G_IF);
    rd_sel_ls      = (gnt == G_LSR);
    mem_arvalid    = (rd_sel_if & if_rd.arvalid) | (rd_sel_ls & ls_rd.arvalid);
    mem_rd.araddr  = rd_sel_if ? if_rd.araddr : ls_rd.araddr;
    mem_rd.arvalid = mem_arvalid;
    if_rd.arready  = rd_sel_if & mem_rd.arready;
    ls_rd.arready  = rd_sel_ls & mem_rd.arready;
    ar_hs          = mem_arvalid & mem_rd.arready;

    // A kill in the same cycle as rvalid drops that response too.
    drop_now       = drop_q | if_kill;
    if_rd.rdata    = mem_rd.rdata;
    if_rd.rresp    = mem_rd.rresp;
    ls_rd.rdata    = mem_rd.rdata;
    ls_rd.rresp    = mem_rd.rresp;
    if_rd.rvalid   = (state_q == RD_WAIT_IF) & mem_rd.rvalid & ~drop_now;
    ls_rd.rvalid   = (state_q == RD_WAIT_LS) & mem_rd.rvalid;
    mem_rready     = 1'b0;
    case (state_q)
      RD_WAIT_IF: mem_rready = drop_now | if_rd.rready;
      RD_WAIT_LS: mem_rready = ls_rd.rready;
      default:    mem_rready = 1'b0;
    endcase
    mem_rd.rready  = mem_rready;
    r_hs           = mem_rd.rvalid & mem_rready;
  end

  // Write channels: in WR_ADDR only the channel still outstanding is driven.
  always_comb begin
    wr_sel_idle    = (gnt == G_LSW);
    wr_addr_st     = (state_q == WR_ADDR);
    mem_awvalid    = ls_wr.awvalid & (wr_sel_idle | (wr_addr_st & ~aw_done_q));
    mem_wvalid     = ls_wr.wvalid  & (wr_sel_idle | (wr_addr_st & ~w_done_q));
    mem_wr.awvalid = mem_awvalid;
    mem_wr.wvalid  = mem_wvalid;
    mem_wr.awaddr  = ls_wr.awaddr;
    mem_wr.wdata   = ls_wr.wdata;
    mem_wr.wstrb   = ls_wr.wstrb;
    ls_wr.awready  = mem_wr.awready & (wr_sel_idle | (wr_addr_st & ~aw_done_q));
    ls_wr.wready   = mem_wr.wready  & (wr_sel_idle | (wr_addr_st & ~w_done_q));
    aw_hs          = mem_awvalid & mem_wr.awready;
    w_hs           = mem_wvalid & mem_wr.wready;
    ls_wr.bvalid   = (state_q == WR_RESP) & mem_wr.bvalid;
    ls_wr.bresp    = mem_wr.bresp;
    mem_bready     = (state_q == WR_RESP) & ls_wr.bready;
    mem_wr.bready  = mem_bready;
    b_hs           = mem_wr.bvalid & mem_bready;
  end

  // Next state, flags, lock and streak
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    drop_d    = 1'b0;
    lock_d    = G_NONE;
    case (state_q)
      IDLE: begin
        aw_done_d = aw_hs;
        w_done_d  = w_hs;
        if (ar_hs)              state_d = (gnt == G_IF) ? RD_WAIT_IF : RD_WAIT_LS;
        else if (aw_hs && w_hs) state_d = WR_RESP;
        else if (aw_hs || w_hs) state_d = WR_ADDR;
        if (gnt != G_NONE && !(ar_hs || aw_hs || w_hs)) lock_d = gnt;
      end
      RD_WAIT_IF: begin
        drop_d = drop_now & ~r_hs;
        if (r_hs) state_d = IDLE;
      end
      RD_WAIT_LS: begin
        if (r_hs) state_d = IDLE;
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // gnt is only non-NONE in IDLE, so handshakes in WR_ADDR are not grants.
    if_grant_ev = (gnt == G_IF) & ar_hs;
    ls_grant_ev = ((gnt == G_LSR) & ar_hs) | ((gnt == G_LSW) & (aw_hs | w_hs));
    streak_d    = streak_q;
    if (if_grant_ev)
      streak_d = 4'd0;
    else if (ls_grant_ev)
      streak_d = !if_rd.arvalid ? 4'd0 :
                 (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
  end

  assign busy = (state_q != IDLE);

`ifdef AXIL_ARB_PERF_CNT_EN
  logic ls_addr_hs;
  assign ls_addr_hs = ((gnt == G_LSR) & ar_hs) | aw_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_grant_cnt <= 32'd0;
      ls_grant_cnt <= 32'd0;
      starve_cnt   <= 32'd0;
    end else begin
      if (if_grant_ev)                        if_grant_cnt <= if_grant_cnt + 32'd1;
      if (ls_addr_hs)                         ls_grant_cnt <= ls_grant_cnt + 32'd1;
      if (if_rd.arvalid && gnt != G_IF)       starve_cnt   <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/axil_mem_arbiter.md
# axil_mem_arbiter

Shares the single AXI-lite memory port between instruction fetch (read-only) and the memory read/write stage (loads and stores). It sits between those two masters and the cache/memory controller. It allows one outstanding transaction at a time, because the memory stage expects its response before it issues the next request. Requests pass through combinationally, so the unlatched memory-stage request still reaches memory in the same cycle.

## Interface
Parameters:
- MAX_LS_STREAK, default 4: consecutive memory-stage grants allowed while fetch waits before fetch is forced ahead; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- if_rd  axil_interface_if.rd_slv  -  fetch read requester.
- ls_rd  axil_interface_if.rd_slv  -  memory-stage read requester.
- ls_wr  axil_interface_if.wr_slv  -  memory-stage write requester.
- mem_rd  axil_interface_if.rd_mst  -  shared read port to memory.
- mem_wr  axil_interface_if.wr_mst  -  shared write port to memory.
- if_kill  input  1  fetch redirect; the response to an outstanding fetch read is discarded.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, RD_WAIT_IF, RD_WAIT_LS, WR_ADDR, WR_RESP.
- IDLE grant: combinational, selecting among if_rd.arvalid, ls_rd.arvalid and ls_wr.awvalid/wvalid.
  - Memory-stage requests win over fetch.
  - Exception: when streak == MAX_LS_STREAK and if_rd.arvalid is high, fetch wins.
  - ls_rd and ls_wr are never both valid.
- Granted read: araddr and arvalid pass to mem_rd; mem_rd.arready returns only to the winner. The loser sees arready = 0.
- Read transitions:
  - On mem_rd.arvalid && arready, go to RD_WAIT_IF or RD_WAIT_LS according to owner.
  - In RD_WAIT_x, mem_rd.rvalid and rdata route to the owner; the other requester sees rvalid = 0.
  - mem_rd.rready = owner's rready, forced to 1 when the response is being discarded.
  - On rvalid && rready, return to IDLE.
- Granted write: aw* and w* pass to mem_wr. AW and W may handshake in different cycles.
  - Internal flags aw_done and w_done track each handshake.
  - If exactly one handshake completes, go to WR_ADDR. In WR_ADDR only the incomplete channel stays driven, and no reads are granted.
  - When both have completed, go to WR_RESP.
  - In WR_RESP, bvalid routes to ls_wr; return to IDLE on bvalid && bready.
  - If AW and W both complete in the same cycle, go straight to WR_RESP.
- streak counter (4-bit):
  - Increments on each memory-stage grant while if_rd.arvalid is high.
  - Clears on any fetch grant, or on a memory-stage grant while fetch is idle.
  - Saturates at MAX_LS_STREAK.
- if_kill:
  - In RD_WAIT_IF: set the drop flag. The response is consumed with rready = 1 and never presented on if_rd.
  - In the same cycle as the fetch rvalid: that response is dropped.
  - In IDLE: no effect. The requester deasserts its own arvalid.
- rresp and bresp pass through unmodified to the owner.

## Timing
- Request path: zero-cycle combinational from requester valid to mem valid, and from mem ready back to requester ready.
- Response path: zero-cycle combinational mem rvalid/bvalid to the owner.
- No new address is accepted in the cycle a response completes. The earliest next arvalid/awvalid handshake is the cycle after.
- Reset (rst low, asynchronous):
  - State: IDLE; streak = 0; aw_done = w_done = drop = 0.
  - Outputs: busy = 0. All arvalid, awvalid, wvalid to memory are 0. All arready, awready, wready, rvalid, bvalid to requesters are 0.
- Reset mid-transaction abandons it; after release, the block restarts from IDLE.
- Grant is stable while a granted arvalid is held without arready. The grant decision is not re-evaluated until the handshake completes or the winner drops arvalid.

## Configuration
- AXIL_ARB_PERF_CNT_EN defined:
  - Adds outputs if_grant_cnt (32), ls_grant_cnt (32) and starve_cnt (32).
  - if_grant_cnt and ls_grant_cnt increment on each address handshake for that requester.
  - starve_cnt increments each cycle if_rd.arvalid is high without a grant.
  - All three reset to 0 and wrap modulo 2^32.
- AXIL_ARB_PERF_CNT_EN undefined: these ports and counters do not exist; arbitration behaviour is identical.

## Test plan
- Fetch-only read to 0x1000 with mem arready immediate and rdata 0xDEADBEEF one cycle later -> if_rd sees arready the same cycle and rvalid/rdata 0xDEADBEEF the next cycle; busy is 1 for one cycle.
- if_rd and ls_rd both valid in IDLE with streak 0 -> ls granted; if_rd.arready = 0; fetch granted in the first IDLE after the ls response.
- Continuous ls reads with fetch pending and MAX_LS_STREAK = 4 -> exactly 4 ls grants, then a fetch grant, then streak = 0.
- Store where mem awready arrives 2 cycles before wready, wstrb 0x0F -> state goes WR_ADDR then WR_RESP; no read is granted in between; ls_wr gets bvalid once.
- Fetch outstanding, if_kill pulsed, then mem rvalid -> if_rd.rvalid stays 0; mem_rd.rready = 1; the arbiter is back in IDLE the next cycle.
- rst asserted low while in RD_WAIT_LS -> all valids and busy go to 0 immediately (asynchronously); after release, the block grants a fresh request normally.
